// File: rtl/sat_alu_pkg.sv
// sat_alu_pkg: opcodes and clamp-limit helpers shared by the saturating ALU pipeline
package sat_alu_pkg;
  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_ACC  = 2'd2;
  localparam logic [1:0] OP_LOAD = 2'd3;
  function automatic logic signed [63:0] max_pos(input int n);
    return (64'sd1 <<< (n - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] min_neg(input int n, input bit sym);
    return -(64'sd1 <<< (n - 1)) + (sym ? 64'sd1 : 64'sd0);
  endfunction
endpackage

// File: rtl/sat_clamp.sv
// sat_clamp: combinational (N+1)-bit to N-bit signed clamp with saturation flag
module sat_clamp
  import sat_alu_pkg::*;
#(
  parameter int N       = 25,
  parameter bit SYM_SAT = 1'b1
) (
  input  logic [N:0]   raw,
  output logic [N-1:0] y,
  output logic         sat
);
  localparam logic signed [63:0] MP64 = max_pos(N);
  localparam logic signed [63:0] MN64 = min_neg(N, SYM_SAT);
  localparam logic [N-1:0] MP = MP64[N-1:0];
  localparam logic [N-1:0] MN = MN64[N-1:0];
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
  logic ovf, sym_hit;
  // symmetric mode also folds an exact most-negative result onto the clamp value
  always_comb begin
    ovf     = raw[N] ^ raw[N-1];
    sym_hit = SYM_SAT && !ovf && (raw[N-1:0] == MOST_NEG);
    sat     = ovf || sym_hit;
    y       = (ovf && !raw[N]) ? MP : sat ? MN : raw[N-1:0];
  end
endmodule

// File: rtl/sat_alu_pipe.sv
// sat_alu_pipe: two-stage saturating add/sub/accumulate/load with valid/ready flow control
module sat_alu_pipe
  import sat_alu_pkg::*;
#(
  parameter int N       = 25,
  parameter bit SYM_SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         sat,
  output logic         sat_sticky,
  input  logic         sticky_clr,
  output logic [N-1:0] acc
);
  logic         s1_valid, s2_load, y_sat;
  logic [1:0]   s1_op;
  logic [N-1:0] s1_a, s1_b, y;
  logic [N:0]   lhs, rhs, raw;
  always_comb begin
    s2_load  = s1_valid && (!out_valid || out_ready);
    in_ready = !s1_valid || s2_load;
    lhs      = (s1_op == OP_ACC) ? {acc[N-1], acc} : {s1_a[N-1], s1_a};
    rhs      = (s1_op == OP_ACC) ? {s1_a[N-1], s1_a} : (s1_op == OP_LOAD) ? '0 : {s1_b[N-1], s1_b};
    raw      = (s1_op == OP_SUB) ? lhs - rhs : lhs + rhs;
  end
  sat_clamp #(.N(N), .SYM_SAT(SYM_SAT)) u_clamp (.raw(raw), .y(y), .sat(y_sat));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_op      <= OP_ADD;
      s1_a       <= '0;
      s1_b       <= '0;
      out_valid  <= 1'b0;
      result     <= '0;
      sat        <= 1'b0;
      acc        <= '0;
      sat_sticky <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op <= op;
          s1_a  <= a;
          s1_b  <= b;
        end
      end
      if (!out_valid || out_ready) out_valid <= s1_valid;
      if (s2_load) begin
        result <= y;
        sat    <= y_sat;
        if (s1_op == OP_ACC || s1_op == OP_LOAD) acc <= y;
      end
      // a saturating result in the same cycle as a clear keeps the flag set
      if (s2_load && y_sat) sat_sticky <= 1'b1;
      else if (sticky_clr) sat_sticky <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sat_alu_pipe.sv
// tb_sat_alu_pipe: directed checks of both clamp modes, flow control, sticky flag and async reset
module tb_sat_alu_pipe;
  localparam int N = 25;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, sticky_clr = 1'b0;
  logic [1:0] op = 2'd0;
  logic [N-1:0] a = '0, b = '0;
  logic in_ready, out_valid, sat, sat_sticky;
  logic [N-1:0] result, acc;
  logic in_ready0, out_valid0, sat0, sat_sticky0;
  logic [N-1:0] result0, acc0;
  int checks = 0, errors = 0;

  sat_alu_pipe #(.N(N), .SYM_SAT(1'b1)) u_sym (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .sat(sat),
    .sat_sticky(sat_sticky), .sticky_clr(sticky_clr), .acc(acc));

  sat_alu_pipe #(.N(N), .SYM_SAT(1'b0)) u_asym (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .op(op), .a(a), .b(b),
    .out_valid(out_valid0), .out_ready(out_ready), .result(result0), .sat(sat0),
    .sat_sticky(sat_sticky0), .sticky_clr(sticky_clr), .acc(acc0));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    in_valid = 1'b1; op = o; a = x; b = y;
    tick();
    in_valid = 1'b0;
  endtask

  logic [1:0]   s_op  [4] = '{2'd3, 2'd2, 2'd2, 2'd2};
  logic [N-1:0] s_a   [4] = '{25'd10, 25'd5, 25'd5, 25'd5};
  logic [N-1:0] s_exp [4] = '{25'd10, 25'd15, 25'd20, 25'd25};
  int ii, ri;
  logic saw_stall;

  initial begin
    #1;
    chk("rst_out_valid", {24'd0, out_valid}, 25'd0);
    chk("rst_in_ready", {24'd0, in_ready}, 25'd1);
    chk("rst_result", result, 25'd0);
    chk("rst_acc", acc, 25'd0);
    chk("rst_sticky", {24'd0, sat_sticky}, 25'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    send(2'd0, 25'h0FFFFFF, 25'h0000001);
    tick();
    chk("pos_valid", {24'd0, out_valid}, 25'd1);
    chk("pos_result", result, 25'h0FFFFFF);
    chk("pos_sat", {24'd0, sat}, 25'd1);
    chk("pos_sticky", {24'd0, sat_sticky}, 25'd1);
    tick();
    chk("pos_drain", {24'd0, out_valid}, 25'd0);

    send(2'd0, 25'h1000001, 25'h1FFFFFF);
    tick();
    chk("neg_sym_result", result, 25'h1000001);
    chk("neg_sym_sat", {24'd0, sat}, 25'd1);
    chk("neg_asym_result", result0, 25'h1000000);
    chk("neg_asym_sat", {24'd0, sat0}, 25'd0);

    send(2'd1, 25'h0000000, 25'h1000000);
    tick();
    chk("sub_asym_result", result0, 25'h0FFFFFF);
    chk("sub_asym_sat", {24'd0, sat0}, 25'd1);

    send(2'd3, 25'h1000000, 25'h0);
    tick();
    chk("load_sym_result", result, 25'h1000001);
    chk("load_sym_sat", {24'd0, sat}, 25'd1);
    chk("load_asym_acc", acc0, 25'h1000000);

    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("clr_sticky", {24'd0, sat_sticky}, 25'd0);
    send(2'd0, 25'h0FFFFFF, 25'h0000001);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("collide_sticky", {24'd0, sat_sticky}, 25'd1);
    tick();

    in_valid = 1'b1; op = 2'd3; a = 25'd10;
    tick();
    op = 2'd2; a = 25'd5;
    tick();
    chk("acc_r0", result, 25'd10);
    tick();
    chk("acc_r1", result, 25'd15);
    tick();
    chk("acc_r2", result, 25'd20);
    in_valid = 1'b0;
    tick();
    chk("acc_r3", result, 25'd25);
    chk("acc_val", acc, 25'd25);
    tick();

    ii = 0; ri = 0; saw_stall = 1'b0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid = ii < 4;
      if (ii < 4) begin op = s_op[ii]; a = s_a[ii]; end
      #1;
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        chk("stall_result", result, (ri < 4) ? s_exp[ri] : 25'h1FFFFFF);
        ri++;
      end
      if (in_valid && in_ready) ii++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stall_count", 25'(ri), 25'd4);
    chk("stall_in_ready_fell", {24'd0, saw_stall}, 25'd1);
    chk("stall_acc", acc, 25'd25);

    send(2'd0, 25'h0FFFFFF, 25'h0000001);
    tick();
    out_ready = 1'b0;
    send(2'd0, 25'd1, 25'd1);
    send(2'd0, 25'd2, 25'd2);
    chk("pre_rst_out_valid", {24'd0, out_valid}, 25'd1);
    chk("pre_rst_in_ready", {24'd0, in_ready}, 25'd0);
    chk("pre_rst_sticky", {24'd0, sat_sticky}, 25'd1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", {24'd0, out_valid}, 25'd0);
    chk("async_acc", acc, 25'd0);
    chk("async_sticky", {24'd0, sat_sticky}, 25'd0);
    chk("async_in_ready", {24'd0, in_ready}, 25'd1);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send(2'd2, 25'd7, 25'd0);
    tick();
    chk("post_rst_valid", {24'd0, out_valid}, 25'd1);
    chk("post_rst_result", result, 25'd7);
    tick();
    chk("post_rst_drain", {24'd0, out_valid}, 25'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
